// File: rtl/wave_capture_if.sv
// wave_capture_if: sample, trigger and readback signals of wave_capture.
// The decim field exists only when WAVE_CAPTURE_DECIM_EN is defined.
interface wave_capture_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  en;
    logic [WIDTH-1:0]      din;
    logic                  arm;
    logic [WIDTH-1:0]      trig_level;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  busy;
    logic                  done;
`ifdef WAVE_CAPTURE_DECIM_EN
    logic [3:0]            decim;
    modport master (output en, din, arm, trig_level, rd_addr, decim, input rd_data, busy, done);
    modport slave  (input en, din, arm, trig_level, rd_addr, decim, output rd_data, busy, done);
`else
    modport master (output en, din, arm, trig_level, rd_addr, input rd_data, busy, done);
    modport slave  (input en, din, arm, trig_level, rd_addr, output rd_data, busy, done);
`endif
endinterface

// File: rtl/wave_capture.sv
// wave_capture: rising-edge triggered recorder of 2**ADDR_WIDTH samples with registered readback.
// Optional sample decimation during capture is enabled by WAVE_CAPTURE_DECIM_EN.
module wave_capture #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    wave_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]      prev_q, prev_d, rd_data_q;
    logic                  prev_vld_q, prev_vld_d;
    logic                  we, trig, take;
    logic [ADDR_WIDTH-1:0] wa;
    logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];

    assign trig = bus.en && prev_vld_q && prev_q < bus.trig_level && bus.din >= bus.trig_level;

`ifdef WAVE_CAPTURE_DECIM_EN
    // dcnt_q counts samples skipped since the last write; the trigger sample is a write
    logic [3:0] dcnt_q, dcnt_d;
    assign take = dcnt_q == bus.decim;
    always_ff @(posedge clk)
        dcnt_q <= rst ? '0 : dcnt_d;
    always_comb begin
        dcnt_d = dcnt_q;
        if (bus.arm || (state_q == ARMED && trig))
            dcnt_d = '0;
        else if (state_q == CAPTURE && bus.en)
            dcnt_d = take ? '0 : dcnt_q + 1'b1;
    end
`else
    assign take = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        we         = 1'b0;
        wa         = ptr_q[ADDR_WIDTH-1:0];
        if (bus.arm) begin
            state_d    = ARMED;
            ptr_d      = '0;
            prev_vld_d = 1'b0;
        end else begin
            case (state_q)
                ARMED: if (bus.en) begin
                    prev_d     = bus.din;
                    prev_vld_d = 1'b1;
                    if (trig) begin
                        we      = 1'b1;
                        wa      = '0;
                        ptr_d   = (ADDR_WIDTH+1)'(1);
                        state_d = CAPTURE;
                    end
                end
                // the extra pointer bit flags the full buffer after the last address is written
                CAPTURE: if (bus.en && take) begin
                    we      = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ptr_d[ADDR_WIDTH] ? DONE : CAPTURE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk)
        if (we) mem[wa] <= bus.din;

    always_ff @(posedge clk)
        rd_data_q <= rst ? '0 : mem[bus.rd_addr];

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = state_q == ARMED || state_q == CAPTURE;
    assign bus.done    = state_q == DONE;
endmodule

// File: doc/wave_capture.md
# wave_capture

Triggered waveform recorder: the capture-side counterpart of the sine generator. It takes a stream of unsigned samples, such as the generator's `dout`, waits for a rising-edge crossing of a programmable level, and writes the next 2**ADDR_WIDTH samples into an internal RAM. Captured samples are read back through a synchronous read port, with the same one-cycle latency as the waveform ROM. The block sits at the end of the signal path and is used for on-board inspection and self-check of generated waveforms.

## Interface
- `WIDTH`, 8, sample width in bits (unsigned, offset-binary).
- `ADDR_WIDTH`, 8, capture buffer address width; depth is 2**ADDR_WIDTH.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `en`  input  1  sample strobe; `din` is valid in this cycle.
- `din`  input  WIDTH  incoming sample.
- `arm`  input  1  single-cycle pulse that starts or restarts arming.
- `trig_level`  input  WIDTH  trigger threshold, unsigned.
- `rd_addr`  input  ADDR_WIDTH  readback address.
- `rd_data`  output  WIDTH  readback data, registered.
- `busy`  output  1  high in ARMED and CAPTURE.
- `done`  output  1  high in DONE.

## Operation
- FSM states:
  - IDLE (reset state).
  - ARMED: waiting for the trigger.
  - CAPTURE: writing samples.
  - DONE: buffer full and frozen.
- `arm` sampled high in any state:
  - Next state is ARMED.
  - The previous-sample register is cleared to invalid.
  - The write pointer is cleared to 0.
  - An in-progress capture is abandoned.
  - `arm` has priority over every other event in the same cycle.
- ARMED:
  - Each `en` cycle stores `din` as the previous sample and marks it valid.
  - Trigger condition: previous sample valid, `prev < trig_level`, and `din >= trig_level`. Comparison is unsigned, full WIDTH.
  - The first `en` sample after arming never triggers.
  - The triggering sample is written at address 0 in the same cycle. The write pointer becomes 1 and the state becomes CAPTURE.
- CAPTURE:
  - Each `en` cycle writes `din` at the write pointer, then increments the pointer.
  - Cycles with `en` low write nothing and hold the pointer.
  - The 2**ADDR_WIDTH-th write (address 2**ADDR_WIDTH−1) moves the state to DONE.
  - The pointer is ADDR_WIDTH+1 bits wide, so full is detected without wrap-around ambiguity.
- DONE:
  - No writes; buffer contents are frozen.
  - `en` is ignored.
  - State is held until `arm` or `rst`.
- Falling crossings, and samples equal to `trig_level` with `prev >= trig_level`, do not trigger.
- `trig_level` of 0 never triggers, because `prev < 0` is impossible.
- Readback:
  - `rd_data` is the RAM content at the `rd_addr` sampled in the previous cycle. It is valid in every state.
  - Reading an address during CAPTURE returns the old or new content. Only reads in DONE are checked.
  - Read and write to the same address in one cycle: `rd_data` returns the old content.
- `rst`:
  - State goes to IDLE, the pointer is cleared, and the previous sample is made invalid.
  - RAM contents are not cleared.

## Timing
- Reset values:
  - `busy` = 0.
  - `done` = 0.
  - `rd_data` = 0 (output register reset).
- `arm` in cycle n: `busy` = 1 from cycle n+1.
- Trigger sample in cycle t: it is stored at address 0 and is readable from cycle t+1.
- Final write in cycle f:
  - `done` = 1 and `busy` = 0 from cycle f+1.
- Continuous `en`: `done` rises exactly 2**ADDR_WIDTH cycles after the trigger cycle.
- Read latency: 1 cycle.
- `rst` dominates `arm`.

## Configuration
- Macro: `WAVE_CAPTURE_DECIM_EN`.
- Defined:
  - Adds input port `decim` [3:0].
  - In CAPTURE, only every (`decim`+1)-th `en` sample is written, counting the trigger sample as the first one written.
  - The decimation counter resets on trigger, `arm` and `rst`.
  - `decim` = 0 behaves identically to the undefined build.
  - ARMED trigger detection still evaluates every `en` sample.
- Undefined:
  - No `decim` port.
  - Every `en` sample in CAPTURE is written.

## Test plan
- Reset: assert `rst` for 2 cycles with `arm` high → `busy` = 0, `done` = 0, `rd_data` = 0.
- Rising ramp:
  - Stimulus: `trig_level` = 128; pulse `arm`; then `din` = 0,1,2,…, wrapping at 255, with `en` = 1 continuously.
  - Trigger on the sample 128 (prev 127).
  - `done` rises 256 cycles after the trigger cycle.
  - Readback: `rd_addr` = k returns (128+k) mod 256 for all k.
- Falling only:
  - Stimulus: `din` = 200 down to 0, `trig_level` = 100, armed.
  - `busy` stays 1, `done` stays 0, and no RAM writes occur.
- Gapped strobe:
  - Same ramp as above with `en` high every 3rd cycle.
  - Same RAM contents as the rising-ramp test.
  - `done` rises 766 cycles after the trigger cycle.
- Abort:
  - Pulse `arm` after 50 captured samples; then feed `din` = 10,20,30,… with level 25.
  - New trigger on 30 (prev 20), which lands at address 0.
  - `done` appears only after 256 further writes.
- `WAVE_CAPTURE_DECIM_EN`:
  - Rising ramp with `decim` = 1.
  - `rd_addr` k returns (128+2k) mod 256.
  - `done` rises 511 cycles after the trigger cycle.
